// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the CPU-side SDRAM port between three requesters: the boot /
//   expansion-ROM loader (L), the Z80 memory path (C) and a DMA requester (D).
//   One access is granted per ce_ref slot. Priority is L > C > D, except that
//   D is moved ahead of C once it has lost STARVE_MAX consecutive slots to C.
//
//   Optional feature (macro ARB_ROMPROT_EN): C or D writes whose address has
//   the top bit set (ROM region) are granted and acknowledged, but mem_we and
//   mem_oe stay low for the slot. Loader writes are never blocked.
//
// Parameters
//   AW          SDRAM byte address width
//   RD_LAT      cycles from the granting ce_ref cycle to read data (2..15)
//   STARVE_MAX  slots D may lose to C before it is forced ahead of C
//
// Ports
//   clk_sys, reset (sync, active-high), ce_ref (one cycle per 16-cycle slot)
//   {l,c,d}_req/_we/_addr/_bank/_din  request groups, req held until ack
//   {l,c,d}_ack                       one-cycle completion pulses
//   rd_data                           read data, valid with a read's ack
//   mem_oe/we/addr/bank/din, mem_dout sdram CPU port
//   grant                             owner: 0 none, 1 L, 2 C, 3 D
module sdram_port_arbiter #(
  parameter int unsigned AW         = 23,
  parameter int unsigned RD_LAT     = 8,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_ref,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [1:0]    l_bank,
  input  logic [7:0]    l_din,
  output logic          l_ack,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [1:0]    c_bank,
  input  logic [7:0]    c_din,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [1:0]    d_bank,
  input  logic [7:0]    d_din,
  output logic          d_ack,
  output logic [7:0]    rd_data,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_bank,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic [1:0]    grant
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_L    = 2'd1,
    OWN_C    = 2'd2,
    OWN_D    = 2'd3
  } owner_t;

  // Counter starts at 0 in the first cycle after the granting edge, so the
  // ack register is loaded one count early to be visible at RD_LAT-1.
  localparam logic [3:0] ACK_CNT = 4'(RD_LAT - 2);

  state_t        state, state_next;
  owner_t        owner, win;
  logic [3:0]    cnt;
  logic [1:0]    starve_cnt;
  logic          slot_we;
  logic          starved;
  logic          rom_block;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [1:0]    w_bank;
  logic [7:0]    w_din;

  assign starved = 32'(starve_cnt) >= STARVE_MAX;
  assign grant   = owner;

  always_comb begin
    win = OWN_NONE;
    if (l_req)                 win = OWN_L;
    else if (d_req && starved) win = OWN_D;
    else if (c_req)            win = OWN_C;
    else if (d_req)            win = OWN_D;
  end

  always_comb begin
    w_we   = 1'b0;
    w_addr = '0;
    w_bank = '0;
    w_din  = '0;
    case (win)
      OWN_L: begin w_we = l_we; w_addr = l_addr; w_bank = l_bank; w_din = l_din; end
      OWN_C: begin w_we = c_we; w_addr = c_addr; w_bank = c_bank; w_din = c_din; end
      OWN_D: begin w_we = d_we; w_addr = d_addr; w_bank = d_bank; w_din = d_din; end
      default: ;
    endcase
  end

`ifdef ARB_ROMPROT_EN
  assign rom_block = w_we && w_addr[AW-1] && (win == OWN_C || win == OWN_D);
`else
  assign rom_block = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ce_ref) state_next = (win == OWN_NONE) ? IDLE : BUSY;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner      <= OWN_NONE;
      cnt        <= '0;
      starve_cnt <= '0;
      slot_we    <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_bank   <= '0;
      mem_din    <= '0;
      rd_data    <= '0;
      l_ack      <= 1'b0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      l_ack <= 1'b0;
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      if (ce_ref) begin
        // A ce_ref always ends the current slot, even if its ack never came.
        owner    <= win;
        cnt      <= '0;
        slot_we  <= w_we;
        mem_oe   <= (win != OWN_NONE) && !w_we;
        mem_we   <= (win != OWN_NONE) && w_we && !rom_block;
        mem_addr <= w_addr;
        mem_bank <= w_bank;
        mem_din  <= w_din;
        if (win == OWN_C && d_req) begin
          if (starve_cnt != 2'b11) starve_cnt <= starve_cnt + 2'd1;
        end else if (win == OWN_D || !d_req) begin
          starve_cnt <= '0;
        end
      end else if (state == BUSY) begin
        if (cnt != 4'hF) cnt <= cnt + 4'd1;
        if (cnt == ACK_CNT) begin
          l_ack <= (owner == OWN_L);
          c_ack <= (owner == OWN_C);
          d_ack <= (owner == OWN_D);
          if (!slot_we) rd_data <= mem_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int AW         = 23;
  localparam int RD_LAT     = 8;
  localparam int STARVE_MAX = 3;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_ref;
  logic          l_req, l_we, c_req, c_we, d_req, d_we;
  logic [AW-1:0] l_addr, c_addr, d_addr;
  logic [1:0]    l_bank, c_bank, d_bank;
  logic [7:0]    l_din, c_din, d_din;
  logic          l_ack, c_ack, d_ack;
  logic [7:0]    rd_data;
  logic          mem_oe, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_bank;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [1:0]    grant;

  sdram_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_bank(l_bank), .l_din(l_din), .l_ack(l_ack),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_bank(c_bank), .c_din(c_din), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_bank(d_bank), .d_din(d_din), .d_ack(d_ack),
    .rd_data(rd_data), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_bank(mem_bank), .mem_din(mem_din), .mem_dout(mem_dout), .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  int phase    = 0;

`ifdef ARB_ROMPROT_EN
  localparam bit ROMPROT = 1'b1;
`else
  localparam bit ROMPROT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Slot-level model: who owns the current slot, what it asked for, and how
  // many cycles have elapsed since the granting edge.
  typedef struct {
    int            owner;
    bit            we;
    logic [AW-1:0] addr;
    logic [1:0]    bank;
    logic [7:0]    din;
    bit            blocked;
  } slot_t;

  slot_t      cur;
  int         age;
  int         d_losses;
  logic [7:0] m_rd;

  always @(posedge clk_sys) begin
    int pick;
    if (reset) begin
      cur      = '{0, 1'b0, '0, '0, '0, 1'b0};
      age      = 0;
      d_losses = 0;
      m_rd     = '0;
    end else if (ce_ref) begin
      if (l_req)                              pick = 1;
      else if (d_req && d_losses >= STARVE_MAX) pick = 3;
      else if (c_req)                         pick = 2;
      else if (d_req)                         pick = 3;
      else                                    pick = 0;
      if (d_req && pick == 2)        d_losses++;
      else if (!d_req || pick == 3)  d_losses = 0;
      case (pick)
        1:       cur = '{1, l_we, l_addr, l_bank, l_din, 1'b0};
        2:       cur = '{2, c_we, c_addr, c_bank, c_din, ROMPROT && c_we && c_addr[AW-1]};
        3:       cur = '{3, d_we, d_addr, d_bank, d_din, ROMPROT && d_we && d_addr[AW-1]};
        default: cur = '{0, 1'b0, '0, '0, '0, 1'b0};
      endcase
      age = 0;
    end else begin
      age++;
      if (cur.owner != 0 && age == RD_LAT - 1 && !cur.we) m_rd = mem_dout;
    end
  end

  always @(negedge clk_sys) begin
    if (checking) begin
      bit ack_now;
      ack_now = (age == RD_LAT - 1);
      chk("grant",    32'(grant),    32'(cur.owner));
      chk("mem_oe",   32'(mem_oe),   32'(cur.owner != 0 && !cur.we));
      chk("mem_we",   32'(mem_we),   32'(cur.owner != 0 && cur.we && !cur.blocked));
      chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      chk("mem_bank", 32'(mem_bank), 32'(cur.bank));
      chk("mem_din",  32'(mem_din),  32'(cur.din));
      chk("l_ack",    32'(l_ack),    32'(ack_now && cur.owner == 1));
      chk("c_ack",    32'(c_ack),    32'(ack_now && cur.owner == 2));
      chk("d_ack",    32'(d_ack),    32'(ack_now && cur.owner == 3));
      chk("rd_data",  32'(rd_data),  32'(m_rd));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
    phase  = (phase + 1) % 16;
    ce_ref = (phase == 0);
  endtask

  // Leaves the bench inside a ce_ref cycle; requests set now are arbitrated
  // on the edge that ends this cycle.
  task automatic to_slot_start();
    do tick(); while (!ce_ref);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int d_acks;
    int exp_grant [8];
    reset  = 1'b1;
    ce_ref = 1'b0;
    {l_req, l_we, c_req, c_we, d_req, d_we} = '0;
    l_addr = '0; c_addr = '0; d_addr = '0;
    l_bank = '0; c_bank = '0; d_bank = '0;
    l_din  = '0; c_din  = '0; d_din  = '0;
    mem_dout = '0;
    ticks(3);
    checking = 1'b1;
    chk("rst_grant",   32'(grant),   0);
    chk("rst_mem_oe",  32'(mem_oe),  0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;

    // L beats C; L write into ROM region is never blocked.
    to_slot_start();
    l_req = 1; l_we = 1; l_addr = 23'h400000; l_bank = 2'd1; l_din = 8'hA5;
    c_req = 1; c_we = 0; c_addr = 23'h001234; c_bank = 2'd2;
    mem_dout = 8'h3C;
    tick();
    chk("t1_grant",    32'(grant),    1);
    chk("t1_mem_we",   32'(mem_we),   1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h400000);
    chk("t1_mem_din",  32'(mem_din),  32'hA5);
    ticks(6);
    chk("t1_no_early_ack", 32'(l_ack), 0);
    tick();
    chk("t1_l_ack", 32'(l_ack), 1);
    l_req = 0;
    tick();
    chk("t1_we_held", 32'(mem_we), 1);

    // C read granted on the following slot.
    to_slot_start();
    tick();
    chk("t2_grant",    32'(grant),    2);
    chk("t2_mem_oe",   32'(mem_oe),   1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h001234);
    ticks(7);
    chk("t2_c_ack",   32'(c_ack),   1);
    chk("t2_rd_data", 32'(rd_data), 32'h3C);
    c_req = 0;

    // C and D both requesting: D forced through once per 4 slots.
    to_slot_start();
    c_req = 1; c_addr = 23'h000100;
    d_req = 1; d_we = 0; d_addr = 23'h000200; d_bank = 2'd3;
    exp_grant = '{2, 2, 2, 3, 2, 2, 2, 3};
    d_acks = 0;
    for (int s = 0; s < 8; s++) begin
      mem_dout = 8'h40 + 8'(s);
      tick();
      chk("t3_grant_seq", 32'(grant), 32'(exp_grant[s]));
      do begin
        tick();
        if (d_ack) d_acks++;
      end while (!ce_ref);
    end
    chk("t3_d_ack_count", 32'(d_acks), 2);
    c_req = 0; d_req = 0;

    // Reset during a C read at counter 3: no ack, outputs cleared.
    to_slot_start();
    c_req = 1; c_addr = 23'h000777;
    tick();
    ticks(3);
    reset = 1;
    tick();
    reset = 0;
    chk("t4_mem_oe", 32'(mem_oe), 0);
    chk("t4_grant",  32'(grant),  0);
    ticks(3);
    chk("t4_no_c_ack", 32'(c_ack), 0);
    to_slot_start();
    tick();
    chk("t4_regrant", 32'(grant), 2);

    // Request withdrawn right after grant still completes.
    c_req = 0;
    ticks(7);
    chk("t5_c_ack", 32'(c_ack), 1);
    to_slot_start();
    tick();
    chk("t5_idle_grant",  32'(grant),  0);
    chk("t5_idle_mem_oe", 32'(mem_oe), 0);

    // D write to ROM region.
    to_slot_start();
    d_req = 1; d_we = 1; d_addr = 23'h4000FF; d_din = 8'h11;
    tick();
    chk("t6_grant",  32'(grant),  3);
    chk("t6_mem_we", 32'(mem_we), ROMPROT ? 0 : 1);
    chk("t6_mem_oe", 32'(mem_oe), 0);
    ticks(7);
    chk("t6_d_ack", 32'(d_ack), 1);
    d_req = 0;
    to_slot_start();
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
